// File: rtl/params_pkg.sv
// params_pkg: shared widths and FSM state encoding for the AXI read arbiter
package params_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: two requester AR/R channels plus the shared slave AR/R channel
// master: arbiter view (drives s_ar*, s_rready, m_arready, m_r*)
// slave:  environment view (drives m_ar*, m_rready, s_arready, s_r*)
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
);
  logic [1:0][ADDR_WIDTH-1:0] m_araddr;
  logic [1:0][7:0] m_arlen;
  logic [1:0][2:0] m_arsize;
  logic [1:0][1:0] m_arburst;
  logic [1:0] m_arvalid, m_arready;
  logic [1:0][DATA_WIDTH-1:0] m_rdata;
  logic [1:0][1:0] m_rresp;
  logic [1:0] m_rlast, m_rvalid, m_rready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst;
  logic s_arvalid, s_arready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rlast, s_rvalid, s_rready;
  modport master (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
           s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready
  );
  modport slave (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
           s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
           s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin pick; req[1:0], rr_ptr in, gnt_idx out
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       gnt_idx
);
  // a lone requester wins; a tie goes to the pointer
  assign gnt_idx = &req ? rr_ptr : req[1];
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: 2:1 AXI read arbiter, one burst outstanding, round-robin grant
// ports: axi_aclk/axi_reset (async active-high), bus (master modport),
//        grant (owning requester), busy (not IDLE), prot_err (sticky burst-length error)
module axi_rd_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  axi_rd_arbiter_if.master  bus,
  output logic              grant,
  output logic              busy,
  output logic              prot_err
);
  arb_state_e state_q;
  logic grant_q, rr_ptr_q, prot_err_q, gnt_idx;
  logic [7:0] beat_cnt_q, len_q;
  logic in_addr, in_data, ar_hs, r_hs;
  logic [1:0] sel;
  rr_arb2 u_rr (.req(bus.m_arvalid), .rr_ptr(rr_ptr_q), .gnt_idx(gnt_idx));
  assign in_addr  = state_q == ADDR;
  assign in_data  = state_q == DATA;
  assign sel      = grant_q ? 2'b10 : 2'b01;
  assign ar_hs    = in_addr && bus.m_arvalid[grant_q] && bus.s_arready;
  assign r_hs     = in_data && bus.s_rvalid && bus.m_rready[grant_q];
  assign grant    = grant_q;
  assign busy     = state_q != IDLE;
  assign prot_err = prot_err_q;
  always_ff @(posedge axi_aclk or posedge axi_reset)
    if (axi_reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      prot_err_q <= 1'b0;
    end else
      case (state_q)
        IDLE: if (|bus.m_arvalid) begin
          grant_q <= gnt_idx;
          state_q <= ADDR;
        end
        ADDR: if (ar_hs) begin
          len_q      <= bus.m_arlen[grant_q];
          beat_cnt_q <= '0;
          state_q    <= DATA;
        end
        DATA: if (r_hs) begin
          beat_cnt_q <= beat_cnt_q + 8'd1;
          // last must coincide exactly with the beat numbered len_q
          if (bus.s_rlast ^ (beat_cnt_q == len_q)) prot_err_q <= 1'b1;
          if (bus.s_rlast) begin
            state_q  <= IDLE;
            rr_ptr_q <= ~grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
  always_comb begin
    bus.s_araddr  = in_addr ? bus.m_araddr[grant_q] : ADDR_WIDTH'(0);
    bus.s_arlen   = in_addr ? bus.m_arlen[grant_q] : 8'd0;
    bus.s_arsize  = in_addr ? bus.m_arsize[grant_q] : 3'd0;
    bus.s_arburst = in_addr ? bus.m_arburst[grant_q] : 2'd0;
    bus.s_arvalid = in_addr && bus.m_arvalid[grant_q];
    bus.m_arready = (in_addr && bus.s_arready) ? sel : 2'b00;
    bus.s_rready  = in_data && bus.m_rready[grant_q];
    bus.m_rvalid  = (in_data && bus.s_rvalid) ? sel : 2'b00;
    for (int i = 0; i < 2; i++) begin
      bus.m_rdata[i] = (in_data && sel[i]) ? bus.s_rdata : DATA_WIDTH'(0);
      bus.m_rresp[i] = (in_data && sel[i]) ? bus.s_rresp : 2'd0;
      bus.m_rlast[i] = in_data && sel[i] && bus.s_rlast;
    end
  end
endmodule
